chacha20_xor_stream: RTL
========================

Name: chacha20_xor_stream

Overview:
Downstream consumer of the ChaCha20 core. It requests keystream blocks from the core and buffers each 512-bit block. It XORs the block word-by-word with a 32-bit plaintext/ciphertext stream using valid/ready handshakes, and advances the block counter per block. The same datapath serves encryption and decryption.

Parameters:
BLOCK_WORDS, 16, 32-bit words per keystream block; only 16 is supported.
DATA_W, 32, stream word width; only 32 is supported.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
init  in  1  one-cycle pulse that starts a new message; ignored while busy=1
init_counter  in  32  initial block counter, latched on init
busy  out  1  high from accepted init until the last word is output or an error occurs
err_ctr_wrap  out  1  sticky; set when a block past counter 0xFFFFFFFF is needed; cleared by the next accepted init
ks_start  out  1  one-cycle pulse to the core's start input
ks_counter  out  32  counter value for the requested block; stable from ks_start until ks_done
ks_done  in  1  core done; ks_block is valid in this cycle
ks_block  in  512  core out_state; word i = ks_block[32*i +: 32]
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid && in_ready
in_data  in  32  plaintext or ciphertext word
in_last  in  1  final word of the message
out_valid  out  1  output word valid
out_ready  in  1  downstream ready
out_data  out  32  in_data XOR keystream word
out_last  out  1  copy of in_last

Behaviour:
- Reset (rst=0, async): state=IDLE. Outputs busy, err_ctr_wrap, ks_start, out_valid, out_last, in_ready = 0; ks_counter, out_data = 0. Word index = 0. Any operation in flight is abandoned, and a ks_done arriving afterwards is ignored.
- FSM:
  - IDLE: init -> REQ; ctr <= init_counter; err_ctr_wrap <= 0.
  - REQ: ks_start=1 for exactly 1 cycle; ks_counter=ctr; -> WAIT.
  - WAIT: in_ready=0; on ks_done, buffer <= ks_block, idx <= 0, -> STREAM. ks_done outside WAIT is ignored.
  - STREAM: in_ready = !out_valid || out_ready. On accept:
    - out_data <= in_data ^ buf[idx]; out_last <= in_last; out_valid <= 1 on the next cycle (1-cycle latency).
    - If in_last -> DRAIN.
    - Else if idx==15: if ctr==0xFFFFFFFF, set err_ctr_wrap and -> DRAIN; else ctr <= ctr+1 and -> REQ.
    - Else idx <= idx+1.
  - DRAIN: in_ready=0; once the output register is empty (or emptied this cycle), busy <= 0 and -> IDLE.
- in_last on idx 15: no further block is requested and the counter is not incremented.
- Output register holds out_data/out_last while out_valid && !out_ready.
- Counter arithmetic is 32-bit. A wrap never wraps silently; it raises the error and truncates the message.
- Byte order inside a word is passed through unchanged; the XOR is bitwise.
- busy=1 in REQ, WAIT, STREAM and DRAIN.
- No prefetch: the stream stalls for the core latency between blocks.
- Throughput: 1 word/cycle within a block when out_ready=1.

Decomposition:
- Shared package chacha20_pkg holds:
  - CHACHA_BLOCK_WORDS=16 and CHACHA_WORD_W=32.
  - The state-encoding localparams IDLE, REQ, WAIT, STREAM, DRAIN.
  - The word-slice index rule.
- One natural sub-module, chacha20_out_reg: the 1-entry output register with its valid/ready handshake.

Test Plan:
- ks_block with every word 32'hA5A5A5A5; init_counter=1; in_data=32'h12345678 with in_last=1 -> out_data=32'hB791F3DD, out_last=1, exactly one ks_start with ks_counter=1, then busy falls.
- 20-word message, ks_block word i = i -> second ks_start carries ks_counter=2; out word 16 = in_data^0; no third request.
- out_ready held 0 for 5 cycles mid-block -> in_ready=0 while the output register is full; out_data stable; no word lost or duplicated.
- init_counter=32'hFFFFFFFF, 17-word message -> 16 words out, err_ctr_wrap=1, no second ks_start, busy=0.
- rst pulsed low during WAIT, then ks_done asserted -> all outputs 0, state IDLE, ks_done ignored; a following init works normally.
- init asserted while busy -> ignored; ks_counter unchanged.

Source files
------------

// File: rtl/chacha20_pkg.sv
// Shared ChaCha20 stream constants, FSM state encoding and keystream word slicing.
package chacha20_pkg;

   localparam int CHACHA_BLOCK_WORDS = 16;
   localparam int CHACHA_WORD_W      = 32;
   localparam int CHACHA_BLOCK_W     = CHACHA_BLOCK_WORDS * CHACHA_WORD_W;
   localparam int CHACHA_IDX_W       = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT   = 3'd2,
      STREAM = 3'd3,
      DRAIN  = 3'd4
   } state_t;

   // Word i of a keystream block lives at bits [32*i +: 32].
   function automatic logic [CHACHA_WORD_W-1:0] ks_word(
      input logic [CHACHA_BLOCK_W-1:0] blk,
      input logic [CHACHA_IDX_W-1:0]   idx
   );
      return blk[{idx, 5'd0} +: CHACHA_WORD_W];
   endfunction

endpackage

// File: rtl/chacha20_out_reg.sv
// One-entry output register with valid/ready handshake; holds data while stalled.
module chacha20_out_reg #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   input  logic         i_last,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_last,
   output logic         o_can_load
);

   logic         r_valid;
   logic [W-1:0] r_data;
   logic         r_last;

   // A new word may enter when the slot is empty or is being drained this cycle.
   assign o_can_load = !r_valid || i_ready;

   // Load on accept, clear valid when consumed, otherwise hold contents.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;

endmodule

// File: rtl/chacha20_xor_stream.sv
// Requests ChaCha20 keystream blocks, buffers them, and XORs them onto a 32-bit stream.
module chacha20_xor_stream
   import chacha20_pkg::*;
#(
   parameter int BLOCK_WORDS = CHACHA_BLOCK_WORDS,
   parameter int DATA_W      = CHACHA_WORD_W
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_init,
   input  logic [31:0]                   i_init_counter,
   output logic                          o_busy,
   output logic                          o_err_ctr_wrap,
   output logic                          o_ks_start,
   output logic [31:0]                   o_ks_counter,
   input  logic                          i_ks_done,
   input  logic [BLOCK_WORDS*DATA_W-1:0] i_ks_block,
   input  logic                          i_in_valid,
   output logic                          o_in_ready,
   input  logic [DATA_W-1:0]             i_in_data,
   input  logic                          i_in_last,
   output logic                          o_out_valid,
   input  logic                          i_out_ready,
   output logic [DATA_W-1:0]             o_out_data,
   output logic                          o_out_last
);

   state_t                          r_state, w_next;
   logic [31:0]                     r_ctr;
   logic [BLOCK_WORDS*DATA_W-1:0]   r_buf;
   logic [CHACHA_IDX_W-1:0]         r_idx;
   logic                            r_err;

   logic                            w_can_load;
   logic                            w_accept;
   logic                            w_last_word;
   logic                            w_wrap;
   logic [DATA_W-1:0]               w_xor;

   assign w_accept    = (r_state == STREAM) && i_in_valid && w_can_load;
   assign w_last_word = (r_idx == CHACHA_IDX_W'(BLOCK_WORDS - 1));
   assign w_wrap      = (r_ctr == 32'hFFFF_FFFF);
   assign w_xor       = i_in_data ^ ks_word(r_buf, r_idx);

   // State register.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_next     = r_state;
      o_ks_start = 1'b0;
      o_in_ready = 1'b0;
      case (r_state)
         IDLE:   if (i_init) w_next = REQ;
         REQ: begin
            o_ks_start = 1'b1;
            w_next     = WAIT;
         end
         WAIT:   if (i_ks_done) w_next = STREAM;
         STREAM: begin
            o_in_ready = w_can_load;
            if (w_accept) begin
               if (i_in_last)        w_next = DRAIN;
               else if (w_last_word) w_next = w_wrap ? DRAIN : REQ;
            end
         end
         // Leave only once the final word has left (or is leaving) the output register.
         DRAIN:  if (w_can_load) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Counter, error flag, keystream buffer and word index.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_ctr <= '0;
         r_err <= 1'b0;
         r_buf <= '0;
         r_idx <= '0;
      end else begin
         case (r_state)
            IDLE: if (i_init) begin
               r_ctr <= i_init_counter;
               r_err <= 1'b0;
            end
            WAIT: if (i_ks_done) begin
               r_buf <= i_ks_block;
               r_idx <= '0;
            end
            STREAM: if (w_accept && !i_in_last) begin
               if (w_last_word) begin
                  // Never wrap the counter: flag it and truncate the message instead.
                  if (w_wrap) r_err <= 1'b1;
                  else        r_ctr <= r_ctr + 32'd1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_busy         = (r_state != IDLE);
   assign o_ks_counter   = r_ctr;
   assign o_err_ctr_wrap = r_err;

   chacha20_out_reg #(.W(DATA_W)) u_out_reg (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_accept),
      .i_data     (w_xor),
      .i_last     (i_in_last),
      .i_ready    (i_out_ready),
      .o_valid    (o_out_valid),
      .o_data     (o_out_data),
      .o_last     (o_out_last),
      .o_can_load (w_can_load)
   );

endmodule
